// File: rtl/segment_fifo.sv
// Packs DIN halfwords MSB-first into DOUT words and queues them; dout is registered, valid the cycle after an accepted rd_en.
// Writes are refused while full and reads while empty, each refusal reported by a one-cycle overflow/underflow pulse.
module segment_fifo #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 128,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int RATIO = DOUT_WIDTH / DIN_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [DOUT_WIDTH-1:0]           mem [DEPTH];
  logic [AW-1:0]                   wptr_q, rptr_q;
  logic [AW:0]                     wcnt_q, wcnt_d;
  logic [CW-1:0]                   acnt_q;
  logic [DOUT_WIDTH-DIN_WIDTH-1:0] asm_q;
  logic [DOUT_WIDTH-1:0]           word_d;
  logic [DOUT_WIDTH-1:0]           dout_q;
  logic                            empty_q, full_q, overflow_q, underflow_q;
  logic                            wr_acc, rd_acc, commit;

  // Shifting in at the bottom leaves the first halfword at the top after RATIO writes.
  always_comb begin
    wr_acc = wr_en && !full_q;
    rd_acc = rd_en && !empty_q;
    commit = wr_acc && (acnt_q == CW'(RATIO - 1));
    word_d = {asm_q, din};
    wcnt_d = wcnt_q + (AW+1)'(commit) - (AW+1)'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (commit) mem[wptr_q] <= word_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      wcnt_q      <= '0;
      acnt_q      <= '0;
      asm_q       <= '0;
      dout_q      <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        acnt_q <= commit ? '0 : acnt_q + CW'(1);
        asm_q  <= commit ? '0 : word_d[DOUT_WIDTH-DIN_WIDTH-1:0];
      end
      if (commit) wptr_q <= wptr_q + AW'(1);
      if (rd_acc) begin
        dout_q <= mem[rptr_q];
        rptr_q <= rptr_q + AW'(1);
      end
      wcnt_q      <= wcnt_d;
      empty_q     <= (wcnt_d == '0);
      full_q      <= (wcnt_d == (AW+1)'(DEPTH));
      overflow_q  <= wr_en && full_q;
      underflow_q <= rd_en && empty_q;
    end
  end

  assign dout      = dout_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_segment_fifo.sv
// Bench for segment_fifo: directed vector table, hand sequences and random traffic against a queue-based model.
module tb_segment_fifo;

  localparam int DEPTH = 512;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  din = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [127:0] dout;
  logic         empty, full, overflow, underflow;

  segment_fifo #(.DIN_WIDTH(16), .DOUT_WIDTH(128), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: complete words in a queue, the partial word as a list of halfwords.
  logic [127:0] mq[$];
  logic [15:0]  part[$];
  logic [127:0] exp_dout = '0;
  logic         exp_ov = 1'b0;
  logic         exp_un = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    part.delete();
    exp_dout = '0;
    exp_ov   = 1'b0;
    exp_un   = 1'b0;
  endtask

  task automatic check_all();
    chk("dout", dout, exp_dout);
    chk("empty", 128'(empty), 128'(mq.size() == 0));
    chk("full", 128'(full), 128'(mq.size() == DEPTH));
    chk("overflow", 128'(overflow), 128'(exp_ov));
    chk("underflow", 128'(underflow), 128'(exp_un));
  endtask

  // One clock: drive inputs, advance the model by the accept rules, compare all outputs.
  task automatic cycle(input logic w, input logic [15:0] d, input logic r);
    logic         pre_full, pre_empty;
    logic [127:0] word;
    pre_full  = (mq.size() == DEPTH);
    pre_empty = (mq.size() == 0);
    wr_en = w; din = d; rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    exp_ov = w && pre_full;
    exp_un = r && pre_empty;
    if (r && !pre_empty) exp_dout = mq.pop_front();
    if (w && !pre_full) begin
      part.push_back(d);
      if (part.size() == 8) begin
        word = '0;
        for (int i = 0; i < 8; i++) word[127-16*i -: 16] = part[i];
        mq.push_back(word);
        part.delete();
      end
    end
    check_all();
  endtask

  typedef struct {
    logic         wr;
    logic [15:0]  din;
    logic         rd;
    logic         exp_empty;
    logic         exp_under;
    logic [127:0] exp_dout;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [127:0] w1, w2;
    w1 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    w2 = 128'h00A1_00A2_00A3_00A4_00A5_00A6_00A7_00A8;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 16'(i + 1), 1'b0, (i < 7), 1'b0, 128'h0};
    tbl[8] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, w1};
    tbl[9] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, w1};
    for (int i = 0; i < 4; i++)
      tbl[10+i] = '{1'b1, 16'(16'hA1 + i), 1'b0, 1'b1, 1'b0, w1};
    tbl[14] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, w1};
    for (int i = 0; i < 3; i++)
      tbl[15+i] = '{1'b1, 16'(16'hA5 + i), 1'b0, 1'b1, 1'b0, w1};
    // 8th write together with a read on empty: read refused, word visible next cycle.
    tbl[18] = '{1'b1, 16'hA8, 1'b1, 1'b0, 1'b1, w1};
    tbl[19] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, w2};

    // Reset state
    #12;
    model_reset();
    chk("reset_dout", dout, 128'h0);
    chk("reset_empty", 128'(empty), 128'h1);
    chk("reset_full", 128'(full), 128'h0);
    chk("reset_overflow", 128'(overflow), 128'h0);
    chk("reset_underflow", 128'(underflow), 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].wr, tbl[i].din, tbl[i].rd);
      chk($sformatf("tbl%0d_empty", i), 128'(empty), 128'(tbl[i].exp_empty));
      chk($sformatf("tbl%0d_underflow", i), 128'(underflow), 128'(tbl[i].exp_under));
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
    end

    // Fill to full, overflow, read at full with a coincident write, then drain in order
    for (int i = 0; i < DEPTH * 8; i++) cycle(1'b1, 16'($urandom), 1'b0);
    chk("fill_full", 128'(full), 128'h1);
    cycle(1'b1, 16'hDEAD, 1'b0);
    chk("extra_write_overflow", 128'(overflow), 128'h1);
    cycle(1'b1, 16'hBEEF, 1'b1);
    chk("write_at_full_with_read_overflow", 128'(overflow), 128'h1);
    chk("write_at_full_with_read_full", 128'(full), 128'h0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 16'h0, 1'b1);
    chk("drain_empty", 128'(empty), 128'h1);

    // Sustained commit+read across several pointer wraps
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 3 * DEPTH * 8; i++) cycle(1'b1, 16'($urandom), (i % 8) == 7);
    cycle(1'b0, 16'h0, 1'b1);
    chk("sustained_final_empty", 128'(empty), 128'h1);

    // Reset mid-burst: 3 words stored, 5 halfwords assembled, dout non-zero
    for (int i = 0; i < 32; i++) cycle(1'b1, 16'(16'h1000 + i), 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h2000 + i), 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_empty", 128'(empty), 128'h1);
    chk("midrst_dout", dout, 128'h0);
    chk("midrst_full", 128'(full), 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'(16'h3000 + i), 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    chk("postrst_word", dout, 128'h3000_3001_3002_3003_3004_3005_3006_3007);

    // Random traffic in phases of differing write/read pressure
    for (int ph = 0; ph < 6; ph++) begin
      int pw, pr;
      pw = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 50 : 15;
      pr = (ph % 3 == 0) ? 10 : (ph % 3 == 1) ? 30 : 90;
      for (int i = 0; i < 600; i++)
        cycle($urandom_range(99) < pw, 16'($urandom), $urandom_range(99) < pr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
